// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port bundle for the program loader.
// The host drives the stream; the loader drives imem and the CPU reset.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata,
    input  cpu_rst, load_done, load_err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata,
    output cpu_rst, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Framed program loader: SYNC, count, words, XOR checksum.
// Holds the CPU in reset until a frame loads with a matching checksum.
module imem_loader #(
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CNT_HI  = 3'd1;
  localparam logic [2:0] CNT_LO  = 3'd2;
  localparam logic [2:0] DATA_HI = 3'd3;
  localparam logic [2:0] DATA_LO = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERR     = 3'd7;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  logic [2:0]      state;
  logic [7:0]      cnt_hi;
  logic [7:0]      hi;
  logic [7:0]      xsum;
  logic [15:0]     cnt;
  logic [ADDR_W:0] idx;

  logic        fire;
  logic [15:0] n;
  logic        n_bad;
  logic        last;

  assign fire  = bus.in_valid & bus.in_ready;
  assign n     = {cnt_hi, bus.in_data};
  assign n_bad = (n == 16'd0) || ({1'b0, n} > CAP);
  // idx is one bit wider than the address so N = 2**ADDR_W cannot wrap
  assign last  = (17'(idx) + 17'd1) == {1'b0, cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_rst    <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_err   <= 1'b0;
      cnt_hi         <= '0;
      hi             <= '0;
      xsum           <= '0;
      cnt            <= '0;
      idx            <= '0;
    end else begin
      bus.in_ready <= 1'b1;
      bus.imem_we  <= 1'b0;
      if (fire) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (bus.in_data == SYNC) begin
              state         <= CNT_HI;
              bus.cpu_rst   <= 1'b1;
              bus.load_done <= 1'b0;
              bus.load_err  <= 1'b0;
            end
          end
          CNT_HI: begin
            cnt_hi <= bus.in_data;
            state  <= CNT_LO;
          end
          CNT_LO: begin
            if (n_bad) begin
              state         <= ERR;
              bus.load_err  <= 1'b1;
              bus.load_done <= 1'b0;
              bus.cpu_rst   <= 1'b1;
            end else begin
              cnt   <= n;
              idx   <= '0;
              xsum  <= '0;
              state <= DATA_HI;
            end
          end
          DATA_HI: begin
            hi    <= bus.in_data;
            xsum  <= xsum ^ bus.in_data;
            state <= DATA_LO;
          end
          DATA_LO: begin
            bus.imem_we    <= 1'b1;
            bus.imem_waddr <= idx[ADDR_W-1:0];
            bus.imem_wdata <= {hi, bus.in_data};
            xsum           <= xsum ^ bus.in_data;
            idx            <= idx + 1'b1;
            state          <= last ? CHECK : DATA_HI;
          end
          CHECK: begin
            if (bus.in_data == xsum) begin
              state         <= DONE;
              bus.load_done <= 1'b1;
              bus.load_err  <= 1'b0;
              bus.cpu_rst   <= 1'b0;
            end else begin
              state         <= ERR;
              bus.load_done <= 1'b0;
              bus.load_err  <= 1'b1;
              bus.cpu_rst   <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule
